ex_mem_stage_reg: RTL and testbench

- Parametrised EX/MEM pipeline register between the EX stage (ALU, branch adder) and the MEM stage of the MIPS datapath.
- Adds a valid bit, stall (hold), flush (bubble insert), a synchronous reset, a separate WB control group and a registered-derived branch-taken output.
- Optionally adds saturating stall and flush event counters for pipeline statistics.

---
 rtl/ex_mem_stage_reg.sv | 101 ++++++++++
 tb/tb_ex_mem_stage_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: carries ALU result, store data, branch target, dest index and MEM/WB control to MEM.
// Latency: 1 cycle from in_* to ou_*; ou_pcsrc is decoded from registered state only (no input-to-output path).
// Backpressure: stall holds every register, flush loads a bubble, and per-edge priority is rst > flush > stall > load.
//
// Ports: clk/rst (synchronous active-high); stall, flush; in_valid plus the EX payload (in_M, in_WB, in_add,
//        in_flag, in_res, in_dat2, in_mux); the registered copies on ou_*; ou_pcsrc = ou_valid & Branch & zero;
//        ou_stall_cnt / ou_flush_cnt are saturating statistics counters.
// Build option: define EX_MEM_STATS_EN to implement the counters. Without it both counter ports are tied to 0.
module ex_mem_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int M_W    = 3,
    parameter int WB_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [M_W-1:0]    in_M,
    input  logic [WB_W-1:0]   in_WB,
    input  logic [DATA_W-1:0] in_add,
    input  logic              in_flag,
    input  logic [DATA_W-1:0] in_res,
    input  logic [DATA_W-1:0] in_dat2,
    input  logic [REG_W-1:0]  in_mux,
    output logic              ou_valid,
    output logic [M_W-1:0]    ou_M,
    output logic [WB_W-1:0]   ou_WB,
    output logic [DATA_W-1:0] ou_add,
    output logic              ou_flag,
    output logic [DATA_W-1:0] ou_res,
    output logic [DATA_W-1:0] ou_dat2,
    output logic [REG_W-1:0]  ou_mux,
    output logic              ou_pcsrc,
    output logic [CNT_W-1:0]  ou_stall_cnt,
    output logic [CNT_W-1:0]  ou_flush_cnt
);

    // MEM control bit positions
    localparam int M_BRANCH = 2;

    // Pipeline register. Control (valid, M, WB, zero flag) is gated by in_valid so that
    // no control bit can ever be set while ou_valid is low. Data fields load regardless.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ou_valid <= 1'b0;
            ou_M     <= '0;
            ou_WB    <= '0;
            ou_add   <= '0;
            ou_flag  <= 1'b0;
            ou_res   <= '0;
            ou_dat2  <= '0;
            ou_mux   <= '0;
        end else if (!stall) begin
            ou_valid <= in_valid;
            ou_M     <= in_valid ? in_M    : '0;
            ou_WB    <= in_valid ? in_WB   : '0;
            ou_flag  <= in_valid ? in_flag : 1'b0;
            ou_add   <= in_add;
            ou_res   <= in_res;
            ou_dat2  <= in_dat2;
            ou_mux   <= in_mux;
        end
    end

    // Branch decision comes only from registered state so MEM sees a glitch-free select.
    assign ou_pcsrc = ou_valid & ou_M[M_BRANCH] & ou_flag;

`ifdef EX_MEM_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             flush_hits_real;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A flush only discards a real instruction if the slot being overwritten holds one:
    // under stall that is the held register, otherwise it is the incoming EX instruction.
    assign flush_hits_real = stall ? ou_valid : in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush && flush_hits_real && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    assign ou_stall_cnt = stall_cnt;
    assign ou_flush_cnt = flush_cnt;
`else
    assign ou_stall_cnt = '0;
    assign ou_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int M_W    = 4;
    localparam int WB_W   = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, stall, flush, in_valid, in_flag;
    logic [M_W-1:0]    in_M;
    logic [WB_W-1:0]   in_WB;
    logic [DATA_W-1:0] in_add, in_res, in_dat2;
    logic [REG_W-1:0]  in_mux;
    logic              ou_valid, ou_flag, ou_pcsrc;
    logic [M_W-1:0]    ou_M;
    logic [WB_W-1:0]   ou_WB;
    logic [DATA_W-1:0] ou_add, ou_res, ou_dat2;
    logic [REG_W-1:0]  ou_mux;
    logic [CNT_W-1:0]  ou_stall_cnt, ou_flush_cnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(
        .DATA_W(DATA_W), .REG_W(REG_W), .M_W(M_W), .WB_W(WB_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_M(in_M), .in_WB(in_WB), .in_add(in_add),
        .in_flag(in_flag), .in_res(in_res), .in_dat2(in_dat2), .in_mux(in_mux),
        .ou_valid(ou_valid), .ou_M(ou_M), .ou_WB(ou_WB), .ou_add(ou_add),
        .ou_flag(ou_flag), .ou_res(ou_res), .ou_dat2(ou_dat2), .ou_mux(ou_mux),
        .ou_pcsrc(ou_pcsrc), .ou_stall_cnt(ou_stall_cnt), .ou_flush_cnt(ou_flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit past it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counters: exact values with the statistics build, constant zero otherwise.
    task automatic chk_cnt(input string tag, input int exp_stall, input int exp_flush);
`ifdef EX_MEM_STATS_EN
        chk({tag, "_stall_cnt"}, 64'(ou_stall_cnt), 64'(exp_stall));
        chk({tag, "_flush_cnt"}, 64'(ou_flush_cnt), 64'(exp_flush));
`else
        chk({tag, "_stall_cnt"}, 64'(ou_stall_cnt), 64'd0);
        chk({tag, "_flush_cnt"}, 64'(ou_flush_cnt), 64'd0);
        if (exp_stall < 0 || exp_flush < 0) $display("note: negative count request ignored");
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(ou_valid), 64'd0);
        chk({tag, "_M"},     64'(ou_M),     64'd0);
        chk({tag, "_WB"},    64'(ou_WB),    64'd0);
        chk({tag, "_add"},   64'(ou_add),   64'd0);
        chk({tag, "_flag"},  64'(ou_flag),  64'd0);
        chk({tag, "_res"},   64'(ou_res),   64'd0);
        chk({tag, "_dat2"},  64'(ou_dat2),  64'd0);
        chk({tag, "_mux"},   64'(ou_mux),   64'd0);
        chk({tag, "_pcsrc"}, 64'(ou_pcsrc), 64'd0);
    endtask

    initial begin
        // Reset for 2 edges with every input at all-ones (stall and flush included).
        rst = 1'b1; stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_flag = 1'b1;
        in_M = '1; in_WB = '1; in_add = '1; in_res = '1; in_dat2 = '1; in_mux = '1;
        step();
        step();
        chk_all_zero("reset");
        chk_cnt("reset", 0, 0);

        // First load after release: 1-cycle latency.
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_M = 4'b0000; in_WB = 2'b01; in_flag = 1'b0;
        in_add = 32'h0; in_res = 32'h0000_1234; in_dat2 = 32'hDEAD_BEEF; in_mux = 5'd3;
        step();
        chk("load_res",   64'(ou_res),   64'h1234);
        chk("load_valid", 64'(ou_valid), 64'd1);
        chk("load_WB",    64'(ou_WB),    64'd1);
        chk("load_dat2",  64'(ou_dat2),  64'hDEAD_BEEF);
        chk("load_mux",   64'(ou_mux),   64'd3);

        // Branch taken.
        in_M = 4'b0100; in_flag = 1'b1; in_add = 32'h0040_0020;
        step();
        chk("br_pcsrc", 64'(ou_pcsrc), 64'd1);
        chk("br_add",   64'(ou_add),   64'h0040_0020);
        chk("br_M",     64'(ou_M),     64'h4);

        // Branch not taken (zero flag low).
        in_flag = 1'b0;
        step();
        chk("brn_pcsrc", 64'(ou_pcsrc), 64'd0);
        chk("brn_flag",  64'(ou_flag),  64'd0);

        // Load, then stall 3 cycles with new inputs; bit 3 of M passes through.
        in_res = 32'hAAAA_5555; in_M = 4'b1010; in_WB = 2'b10; in_flag = 1'b0;
        step();
        chk("pre_stall_res", 64'(ou_res), 64'hAAAA_5555);
        chk("pre_stall_M",   64'(ou_M),   64'hA);
        stall = 1'b1; in_res = 32'h1111_1111; in_M = 4'b0000; in_WB = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_res", 64'(ou_res), 64'hAAAA_5555);
        end
        chk("stall_M",  64'(ou_M),  64'hA);
        chk("stall_WB", 64'(ou_WB), 64'h2);
        chk_cnt("stall3", 3, 0);

        // Flush wins over stall; held register is a real instruction -> counted.
        flush = 1'b1;
        step();
        chk_all_zero("flush_stall");
        chk_cnt("flush_stall", 3, 1);

        // Flush without stall, incoming instruction invalid -> not counted.
        stall = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_inv_valid", 64'(ou_valid), 64'd0);
        chk_cnt("flush_inv", 3, 1);

        // Flush without stall, incoming instruction valid -> counted.
        in_valid = 1'b1; in_M = 4'b0111;
        step();
        chk("flush_val_M", 64'(ou_M), 64'd0);
        chk_cnt("flush_val", 3, 2);

        // Flush under stall while held slot is a bubble -> not counted even with in_valid=1.
        stall = 1'b1;
        step();
        chk_cnt("flush_bubble", 3, 2);

        // Invalid load: control gated off, data still captured.
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_M = 4'b1111; in_WB = 2'b11; in_mux = 5'd9; in_flag = 1'b1; in_res = 32'h55;
        step();
        chk("inv_M",     64'(ou_M),     64'd0);
        chk("inv_WB",    64'(ou_WB),    64'd0);
        chk("inv_mux",   64'(ou_mux),   64'd9);
        chk("inv_pcsrc", 64'(ou_pcsrc), 64'd0);
        chk("inv_flag",  64'(ou_flag),  64'd0);
        chk("inv_valid", 64'(ou_valid), 64'd0);
        chk("inv_res",   64'(ou_res),   64'h55);

        // Saturation: 20 more stall cycles from 3 -> stops at 15.
        stall = 1'b1; in_mux = 5'd30;
        for (int i = 0; i < 20; i++) step();
        chk("sat_mux", 64'(ou_mux), 64'd9);
        chk_cnt("sat", 15, 2);

        // Reset with load conditions present clears everything, counters included.
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; in_M = 4'b0100; in_flag = 1'b1;
        step();
        chk_all_zero("rst2");
        chk_cnt("rst2", 0, 0);

        // Resume loading after reset.
        rst = 1'b0; in_add = 32'h0000_0080;
        step();
        chk("resume_pcsrc", 64'(ou_pcsrc), 64'd1);
        chk("resume_add",   64'(ou_add),   64'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
